// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response and data-memory bus of the load/store unit.
//
// Request channel : req_valid, req_ready, req_we, req_addr, req_wdata,
//                   req_size, req_sext
// Response channel: rsp_valid, rsp_rdata, rsp_err
// Memory channel  : mem_address, mem_data_in, mem_wr_en, mem_size,
//                   mem_sz_ex, mem_data_out
//
// Modports:
//   slave  - the lsu_ctrl block itself
//   master - its environment (core execute stage plus the data memory)
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_wr_en;
    logic [1:0]  mem_size;
    logic        mem_sz_ex;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_sext,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex,
        input  mem_data_out
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_sext,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex,
        output mem_data_out
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the execute stage and a
// byte-addressable data memory. One request at a time; the result is
// returned on a single-cycle response strobe.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - lsu_ctrl_if.slave: request (req_*), response (rsp_*) and
//          memory (mem_*) channels
//
// Parameters:
//   MEM_BYTES - memory size in bytes; valid addresses 0..MEM_BYTES-1
//
// Build option:
//   LSU_SPLIT_EN - when defined, misaligned half/word accesses are split
//                  into sequential byte accesses and reassembled. When
//                  undefined they are rejected with rsp_err.
//
// Latency from handshake cycle T: aligned access in T+1, response T+2;
// split access bytes in T+1..T+n, response T+n+1; error response T+1.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);

`ifdef LSU_SPLIT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        RESP   = 2'd3
    } state_t;
`endif

    state_t state;

    logic        we_q;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem_address_q;
    logic [31:0] mem_data_in_q;
    logic        mem_wr_en_q;
    logic [1:0]  mem_size_q;
    logic        mem_sz_ex_q;

    // Request decode
    logic [2:0]  req_nbytes;
    logic [32:0] req_last;
    logic        req_bad;
    logic        req_misaligned;

    always_comb begin
        req_nbytes = 3'd1;
        case (bus.req_size)
            2'b01:   req_nbytes = 3'd2;
            2'b10:   req_nbytes = 3'd4;
            default: req_nbytes = 3'd1;
        endcase
        // 33-bit sum so an address near 2^32 cannot wrap into range
        req_last = {1'b0, bus.req_addr} + {30'b0, req_nbytes} - 33'd1;
        req_bad  = (bus.req_size == 2'b11) || (req_last >= 33'(MEM_BYTES));
        req_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

`ifdef LSU_SPLIT_EN
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  idx_q;
    logic [31:0] result_q;

    logic [1:0]  idx_nxt;
    logic        split_last;
    logic [31:0] split_bytes;
    logic [31:0] split_final;

    always_comb begin
        idx_nxt    = idx_q + 2'd1;
        split_last = (size_q == 2'b01) ? (idx_q == 2'd1) : (idx_q == 2'd3);
        // Result including the byte being read this cycle, so the final
        // response does not need an extra cycle to fold it in.
        split_bytes = result_q;
        split_bytes[{idx_q, 3'b000} +: 8] = bus.mem_data_out[7:0];
        split_final = split_bytes;
        if (size_q == 2'b01) begin
            split_final[31:16] = {16{sext_q & split_bytes[15]}};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_size_q    <= '0;
            mem_sz_ex_q   <= 1'b0;
`ifdef LSU_SPLIT_EN
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            sext_q        <= 1'b0;
            idx_q         <= '0;
            result_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= bus.req_we;
`ifdef LSU_SPLIT_EN
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        size_q      <= bus.req_size;
                        sext_q      <= bus.req_sext;
                        idx_q       <= '0;
                        result_q    <= '0;
`endif
                        if (req_bad) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (!req_misaligned) begin
                            state         <= SINGLE;
                            mem_address_q <= bus.req_addr;
                            mem_data_in_q <= bus.req_wdata;
                            mem_wr_en_q   <= bus.req_we;
                            mem_size_q    <= bus.req_size;
                            mem_sz_ex_q   <= bus.req_sext;
                        end else begin
`ifdef LSU_SPLIT_EN
                            state         <= SPLIT;
                            mem_address_q <= bus.req_addr;
                            mem_data_in_q <= {24'b0, bus.req_wdata[7:0]};
                            mem_wr_en_q   <= bus.req_we;
                            mem_size_q    <= 2'b00;
                            mem_sz_ex_q   <= 1'b0;
`else
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
`endif
                        end
                    end
                end

                SINGLE: begin
                    state         <= RESP;
                    rsp_valid_q   <= 1'b1;
                    rsp_err_q     <= 1'b0;
                    rsp_rdata_q   <= we_q ? '0 : bus.mem_data_out;
                    mem_address_q <= '0;
                    mem_data_in_q <= '0;
                    mem_wr_en_q   <= 1'b0;
                    mem_size_q    <= '0;
                    mem_sz_ex_q   <= 1'b0;
                end

`ifdef LSU_SPLIT_EN
                SPLIT: begin
                    if (!we_q) begin
                        result_q <= split_bytes;
                    end
                    if (split_last) begin
                        state         <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b0;
                        rsp_rdata_q   <= we_q ? '0 : split_final;
                        mem_address_q <= '0;
                        mem_data_in_q <= '0;
                        mem_wr_en_q   <= 1'b0;
                        mem_size_q    <= '0;
                        mem_sz_ex_q   <= 1'b0;
                    end else begin
                        idx_q         <= idx_nxt;
                        mem_address_q <= addr_q + {30'b0, idx_nxt};
                        mem_data_in_q <= {24'b0, wdata_q[{idx_nxt, 3'b000} +: 8]};
                    end
                end
`endif

                RESP: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_size    = mem_size_q;
    assign bus.mem_sz_ex   = mem_sz_ex_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a byte-array data
// memory and a transaction-level reference model of loads and stores.
`timescale 1ns/1ps
module tb_lsu_ctrl;
    localparam int unsigned MEM_BYTES = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read with size/extension, write on clock edge
    logic [7:0]  mem [MEM_BYTES] = '{default: 8'h00};
    int unsigned mnb;
    logic [31:0] mrd;

    always_comb begin
        mnb = 1;
        if (bus.mem_size == 2'b01) mnb = 2;
        else if (bus.mem_size == 2'b10) mnb = 4;
        mrd = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (i < mnb && bus.mem_address + i < MEM_BYTES)
                mrd[8*i +: 8] = mem[6'(bus.mem_address + i)];
        if (bus.mem_sz_ex && mnb == 1) mrd[31:8] = {24{mrd[7]}};
        else if (bus.mem_sz_ex && mnb == 2) mrd[31:16] = {16{mrd[15]}};
    end
    assign bus.mem_data_out = mrd;

    always @(posedge clk)
        if (bus.mem_wr_en)
            for (int unsigned i = 0; i < 4; i++)
                if (i < mnb && bus.mem_address + i < MEM_BYTES)
                    mem[6'(bus.mem_address + i)] <= bus.mem_data_in[8*i +: 8];

    // Reference model: memory image plus per-request expected outcome
    logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

    task automatic ref_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic sext,
                             output logic [31:0] e_rdata, output logic e_err,
                             output int e_lat, output int e_wr);
        int unsigned nb;
        logic aligned, can_split;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        aligned = (addr % nb) == 0;
`ifdef LSU_SPLIT_EN
        can_split = 1'b1;
`else
        can_split = 1'b0;
`endif
        e_err = (size == 2'b11) || ({32'b0, addr} + 64'(nb) > 64'(MEM_BYTES)) ||
                (!aligned && !can_split);
        e_rdata = '0;
        e_lat   = 1;
        e_wr    = 0;
        if (!e_err) begin
            e_lat = aligned ? 2 : int'(nb) + 1;
            if (we) begin
                e_wr = aligned ? 1 : int'(nb);
                for (int unsigned i = 0; i < nb; i++)
                    ref_mem[6'(addr + i)] = 8'(wdata >> (8 * i));
            end else begin
                for (int unsigned i = 0; i < nb; i++)
                    e_rdata = e_rdata | (32'(ref_mem[6'(addr + i)]) << (8 * i));
                if (sext && nb < 4 && e_rdata[8*nb-1])
                    e_rdata = e_rdata | (32'hFFFF_FFFF << (8 * nb));
            end
        end
    endtask

    // Write log of the most recent request
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [1:0]  wr_size_q [$];

    // Drives one request and observes the DUT; all values are sampled 1ns
    // after a rising edge. lat counts cycles from handshake to rsp_valid.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sext,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wr, output logic to, output logic pulse_ok,
                          output logic busy_ok);
        int n;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_size_q.delete();
        to = 1'b0;
        n  = 0;
        while (bus.req_ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        if (bus.req_ready !== 1'b1) to = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_size  = size;
        bus.req_sext  = sext;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();
        lat     = 1;
        wr      = 0;
        busy_ok = 1'b1;
        while (bus.rsp_valid !== 1'b1 && lat < 12) begin
            if (bus.req_ready !== 1'b0) busy_ok = 1'b0;
            if (bus.mem_wr_en === 1'b1) begin
                wr++;
                wr_addr_q.push_back(bus.mem_address);
                wr_data_q.push_back(bus.mem_data_in);
                wr_size_q.push_back(bus.mem_size);
            end
            @(posedge clk); #1; lat++;
        end
        if (bus.rsp_valid !== 1'b1) to = 1'b1;
        if (bus.req_ready !== 1'b0 || bus.mem_wr_en !== 1'b0) busy_ok = 1'b0;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(posedge clk); #1;
        pulse_ok = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) begin
            errors++; $display("FAIL reset_rsp: got %b expected 00", {bus.rsp_valid, bus.rsp_err});
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rsp_rdata);
        end
        checks++;
        if ({bus.mem_address, bus.mem_data_in, bus.mem_wr_en, bus.mem_size, bus.mem_sz_ex} !== 68'h0) begin
            errors++; $display("FAIL reset_mem: addr %h data %h we %b size %b sx %b expected all 0",
                               bus.mem_address, bus.mem_data_in, bus.mem_wr_en, bus.mem_size, bus.mem_sz_ex);
        end
        rst = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 5) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_aligned_word();
        logic [31:0] rdata, e_rdata;
        logic err, to, pok, bok, e_err;
        int lat, wr, e_lat, e_wr;
        ref_apply(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (wr != 1 || err !== 1'b0 || to !== 1'b0) begin
            errors++; $display("FAIL aligned_store: wr_cycles %0d err %b timeout %b expected 1 0 0", wr, err, to);
        end
        checks++;
        if (wr_size_q.size() != 1 || wr_size_q[0] !== 2'b10 || wr_addr_q[0] !== 32'h10) begin
            errors++; $display("FAIL aligned_store_bus: writes %0d expected 1 size 10 addr 10", wr_size_q.size());
        end
        ref_apply(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++; $display("FAIL aligned_load: got %h err %b expected deadbeef err 0", rdata, err);
        end
        checks++;
        if (lat != 2 || to !== 1'b0 || pok !== 1'b1 || bok !== 1'b1) begin
            errors++; $display("FAIL aligned_load_timing: lat %0d to %b pulse %b busy %b expected 2 0 1 1",
                               lat, to, pok, bok);
        end
    endtask

    task automatic test_byte_ext();
        logic [31:0] rdata, e_rdata;
        logic err, to, pok, bok, e_err;
        int lat, wr, e_lat, e_wr;
        ref_apply(1'b1, 32'h20, 32'h0000_0080, 2'b00, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b1, 32'h20, 32'h0000_0080, 2'b00, 1'b0, rdata, err, lat, wr, to, pok, bok);
        ref_apply(1'b0, 32'h20, 32'h0, 2'b00, 1'b1, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, 32'h20, 32'h0, 2'b00, 1'b1, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (rdata !== 32'hFFFFFF80 || err !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL byte_sext: got %h err %b lat %0d expected ffffff80 0 2", rdata, err, lat);
        end
        ref_apply(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (rdata !== 32'h00000080 || err !== 1'b0) begin
            errors++; $display("FAIL byte_zext: got %h err %b expected 00000080 0", rdata, err);
        end
    endtask

    task automatic test_misaligned_word();
        logic [31:0] rdata, e_rdata;
        logic err, to, pok, bok, e_err;
        int lat, wr, e_lat, e_wr;
        logic [31:0] exp_b [4] = '{32'h44, 32'h33, 32'h22, 32'h11};
        ref_apply(1'b1, 32'h05, 32'h11223344, 2'b10, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b1, 32'h05, 32'h11223344, 2'b10, 1'b0, rdata, err, lat, wr, to, pok, bok);
`ifdef LSU_SPLIT_EN
        checks++;
        if (wr != 4 || err !== 1'b0 || lat != 5) begin
            errors++; $display("FAIL mis_word_store: wr %0d err %b lat %0d expected 4 0 5", wr, err, lat);
        end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            checks++;
            if (wr_addr_q[i] !== 32'(5 + i) || wr_data_q[i] !== exp_b[i] || wr_size_q[i] !== 2'b00) begin
                errors++; $display("FAIL mis_word_byte%0d: addr %h data %h size %b expected %h %h 00",
                                   i, wr_addr_q[i], wr_data_q[i], wr_size_q[i], 32'(5 + i), exp_b[i]);
            end
        end
        ref_apply(1'b0, 32'h05, 32'h0, 2'b10, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, 32'h05, 32'h0, 2'b10, 1'b0, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (rdata !== 32'h11223344 || err !== 1'b0 || lat != 5 || pok !== 1'b1) begin
            errors++; $display("FAIL mis_word_load: got %h err %b lat %0d expected 11223344 0 5", rdata, err, lat);
        end
`else
        checks++;
        if (err !== 1'b1 || rdata !== 32'h0 || lat != 1 || wr != 0) begin
            errors++; $display("FAIL mis_word_reject: err %b rdata %h lat %0d wr %0d expected 1 0 1 0",
                               err, rdata, lat, wr);
        end
        checks++;
        if (exp_b[0] !== 32'h44 || e_err !== 1'b1) begin
            errors++; $display("FAIL mis_word_model: err %b expected 1", e_err);
        end
`endif
    endtask

    task automatic test_misaligned_half();
        logic [31:0] rdata, e_rdata;
        logic err, to, pok, bok, e_err;
        int lat, wr, e_lat, e_wr;
        ref_apply(1'b1, 32'h0B, 32'h34, 2'b00, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b1, 32'h0B, 32'h34, 2'b00, 1'b0, rdata, err, lat, wr, to, pok, bok);
        ref_apply(1'b1, 32'h0C, 32'hF2, 2'b00, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b1, 32'h0C, 32'hF2, 2'b00, 1'b0, rdata, err, lat, wr, to, pok, bok);
        ref_apply(1'b0, 32'h0B, 32'h0, 2'b01, 1'b1, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, 32'h0B, 32'h0, 2'b01, 1'b1, rdata, err, lat, wr, to, pok, bok);
`ifdef LSU_SPLIT_EN
        checks++;
        if (rdata !== 32'hFFFFF234 || err !== 1'b0 || lat != 3) begin
            errors++; $display("FAIL mis_half_sext: got %h err %b lat %0d expected fffff234 0 3", rdata, err, lat);
        end
        ref_apply(1'b0, 32'h0B, 32'h0, 2'b01, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, 32'h0B, 32'h0, 2'b01, 1'b0, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (rdata !== 32'h0000F234 || err !== 1'b0) begin
            errors++; $display("FAIL mis_half_zext: got %h err %b expected 0000f234 0", rdata, err);
        end
`else
        checks++;
        if (rdata !== 32'h0 || err !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL mis_half_reject: got %h err %b lat %0d expected 0 1 1", rdata, err, lat);
        end
`endif
    endtask

    task automatic test_errors();
        logic [31:0] rdata, e_rdata;
        logic err, to, pok, bok, e_err;
        int lat, wr, e_lat, e_wr;
        logic        t_we   [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_addr [9] = '{32'h3E, 32'h00, 32'h00, 32'hFFFFFFFC, 32'h40,
                                    32'h3F, 32'h3C, 32'h3E, 32'h01};
        logic [1:0]  t_size [9] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        logic        t_err  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef LSU_SPLIT_EN
        t_err[8] = 1'b0;
`endif
        for (int i = 0; i < 9; i++) begin
            ref_apply(t_we[i], t_addr[i], 32'hA5C3_5A3C, t_size[i], 1'b1, e_rdata, e_err, e_lat, e_wr);
            do_req(t_we[i], t_addr[i], 32'hA5C3_5A3C, t_size[i], 1'b1, rdata, err, lat, wr, to, pok, bok);
            checks++;
            if (err !== t_err[i]) begin
                errors++; $display("FAIL err_case%0d_flag: got %b expected %b", i, err, t_err[i]);
            end
            checks++;
            if (rdata !== e_rdata || lat != e_lat || wr != e_wr || to !== 1'b0) begin
                errors++; $display("FAIL err_case%0d_rsp: rdata %h lat %0d wr %0d expected %h %0d %0d",
                                   i, rdata, lat, wr, e_rdata, e_lat, e_wr);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rdata, e_rdata, base;
        logic err, to, pok, bok, e_err;
        int lat, wr, e_lat, e_wr, n, seen;
`ifdef LSU_SPLIT_EN
        base = 32'h21;
`else
        base = 32'h20;
`endif
        ref_apply(1'b1, base + 1, 32'h5A, 2'b00, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b1, base + 1, 32'h5A, 2'b00, 1'b0, rdata, err, lat, wr, to, pok, bok);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = base;
        bus.req_wdata = 32'hA1B2C3D4;
        bus.req_size  = 2'b10;
        bus.req_sext  = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
`ifdef LSU_SPLIT_EN
        @(posedge clk); #1;
        ref_mem[6'(base)] = 8'hD4;
`endif
        checks++;
        if (bus.mem_wr_en !== 1'b1) begin
            errors++; $display("FAIL midrst_pre_write: got %b expected 1", bus.mem_wr_en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_wr_en} !== 3'b000 ||
            {bus.mem_address, bus.mem_data_in} !== 64'h0) begin
            errors++; $display("FAIL midrst_outputs: ready %b rsp %b we %b addr %h data %h expected all 0",
                               bus.req_ready, bus.rsp_valid, bus.mem_wr_en, bus.mem_address, bus.mem_data_in);
        end
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) seen++;
        end
        rst = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 5) begin
            if (bus.rsp_valid === 1'b1) seen++;
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1 || seen != 0) begin
            errors++; $display("FAIL midrst_recover: ready %b rsp_seen %0d expected 1 0", bus.req_ready, seen);
        end
        ref_apply(1'b0, base + 1, 32'h0, 2'b00, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, base + 1, 32'h0, 2'b00, 1'b0, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (rdata !== 32'h5A || err !== 1'b0) begin
            errors++; $display("FAIL midrst_uncommitted: got %h err %b expected 0000005a 0", rdata, err);
        end
        ref_apply(1'b0, base, 32'h0, 2'b00, 1'b0, e_rdata, e_err, e_lat, e_wr);
        do_req(1'b0, base, 32'h0, 2'b00, 1'b0, rdata, err, lat, wr, to, pok, bok);
        checks++;
        if (rdata !== e_rdata || err !== 1'b0) begin
            errors++; $display("FAIL midrst_first_byte: got %h err %b expected %h 0", rdata, err, e_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, rdata, e_rdata;
        logic [1:0] size;
        logic we, sext, err, to, pok, bok, e_err;
        int lat, wr, e_lat, e_wr;
        for (int k = 0; k < 80; k++) begin
            we    = 1'($urandom_range(0, 1));
            sext  = 1'($urandom_range(0, 1));
            wdata = $urandom();
            size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 67));
            ref_apply(we, addr, wdata, size, sext, e_rdata, e_err, e_lat, e_wr);
            do_req(we, addr, wdata, size, sext, rdata, err, lat, wr, to, pok, bok);
            checks++;
            if (to !== 1'b0 || pok !== 1'b1 || bok !== 1'b1) begin
                errors++; $display("FAIL rand%0d_protocol: timeout %b pulse %b busy %b expected 0 1 1",
                                   k, to, pok, bok);
            end
            checks++;
            if (rdata !== e_rdata) begin
                errors++; $display("FAIL rand%0d_rdata: we %b addr %h size %b sext %b got %h expected %h",
                                   k, we, addr, size, sext, rdata, e_rdata);
            end
            checks++;
            if (err !== e_err) begin
                errors++; $display("FAIL rand%0d_err: addr %h size %b got %b expected %b", k, addr, size, err, e_err);
            end
            checks++;
            if (lat != e_lat || wr != e_wr) begin
                errors++; $display("FAIL rand%0d_timing: lat %0d wr %0d expected %0d %0d", k, lat, wr, e_lat, e_wr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_size  = '0;
        bus.req_sext  = 1'b0;
        test_reset();
        test_aligned_word();
        test_byte_ext();
        test_misaligned_word();
        test_misaligned_half();
        test_errors();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator that sits between the core's execute stage and the byte-addressable data memory. It accepts one load or store request at a time and drives the memory's address, data, write-enable, size and sign/zero-extend inputs. Misaligned half-word and word accesses are split into sequential byte accesses and reassembled, and out-of-range or illegal-size requests are rejected. The result is returned through a single-cycle response strobe.

## Interface
- `MEM_BYTES`, 64: memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_sext` in 1: load result extension; 1 = sign, 0 = zero.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: load result (0 for stores and errors).
- `rsp_err` out 1: request rejected; qualified by `rsp_valid`.
- `mem_address` out 32: to memory `address`.
- `mem_data_in` out 32: to memory `data_in`.
- `mem_wr_en` out 1: to memory `wr_en`.
- `mem_size` out 2: to memory `mem_size`.
- `mem_sz_ex` out 1: to memory `sz_ex`.
- `mem_data_out` in 32: from memory; combinational read of the current `mem_address`.

## Operation
- States:
  - IDLE: `req_ready`=1 while `rst` is high.
  - SINGLE: one access.
  - SPLIT: byte loop.
  - RESP.
- In IDLE, a handshake (`req_valid` & `req_ready`) registers we/addr/wdata/size/sext, then:
  - `size`=11, or addr+nbytes-1 ≥ `MEM_BYTES` (33-bit compare, no wrap): go to RESP with `err`=1 and no memory access. nbytes = 1/2/4.
  - Aligned (byte; half with addr[0]=0; word with addr[1:0]=00): go to SINGLE.
  - Otherwise: go to SPLIT with idx=0.
- SINGLE: drive `mem_address`=addr, `mem_size`=size, `mem_sz_ex`=sext, `mem_wr_en`=we, `mem_data_in`=wdata. Capture `mem_data_out` into the result at the cycle end, then go to RESP.
- SPLIT, for each idx from 0 to nbytes-1:
  - Drive `mem_address`=addr+idx, `mem_size`=00, `mem_sz_ex`=0, `mem_wr_en`=we, `mem_data_in`={24'b0, wdata[8*idx+7:8*idx]}.
  - On a load, capture `mem_data_out[7:0]` into result byte idx.
  - After idx = nbytes-1, go to RESP.
  - Loads apply extension in RESP: for half, bits 31:16 = sext ? bit 15 : 0.
- RESP: `rsp_valid`=1 and `rsp_rdata`=result (0 for store or err). Go to IDLE. `req_ready`=0 in all states except IDLE.
- Outside SINGLE and SPLIT: `mem_wr_en`=0, and `mem_address`/`mem_data_in`/`mem_size`/`mem_sz_ex`=0.
- A new request is never accepted in the same cycle as `rsp_valid`.

## Timing
- Reset, while `rst`=0: state IDLE; `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; all `mem_*` outputs 0.
- Reset asserted mid-access: the access is aborted immediately, with no response. Memory bytes already written in SPLIT stay written.
- Latency, counting the handshake cycle as T:
  - Aligned access: memory access in T+1, `rsp_valid` in T+2.
  - Split access: bytes in T+1..T+nbytes, `rsp_valid` in T+nbytes+1.
  - Error: `rsp_valid` in T+1.
- Writes commit at the rising edge that ends each SINGLE or SPLIT cycle. Loads are sampled at that same edge.
- Throughput: at most one request per (latency + 1) cycles, because IDLE must be re-entered.

## Configuration
- `LSU_SPLIT_EN` defined: misaligned accesses are split as described.
- `LSU_SPLIT_EN` undefined:
  - The SPLIT state and byte counter are not built.
  - A misaligned request goes IDLE→RESP with `rsp_err`=1 and `rsp_rdata`=0, with no memory access, and `rsp_valid` in T+1.

## Test plan
- Aligned word store then load:
  - Stimulus: store 0xDEADBEEF to 0x10, then load a word from 0x10.
  - Response: the store gives `mem_wr_en`=1 for exactly one cycle with `mem_size`=10. The load gives `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, with `rsp_valid` 2 cycles after the handshake.
- Byte sign/zero extension:
  - Stimulus: mem[0x20]=0x80. Load a byte with sext=1, then repeat with sext=0.
  - Response: 0xFFFFFF80, then 0x00000080.
- Misaligned word, with `LSU_SPLIT_EN`:
  - Stimulus: store 0x11223344 to 0x05, then load a word from 0x05.
  - Response: four byte writes at 0x05..0x08 (0x44, 0x33, 0x22, 0x11). The load returns 0x11223344 with `rsp_valid` 5 cycles after the handshake.
- Misaligned half-word load, with `LSU_SPLIT_EN`:
  - Stimulus: mem[0x0B]=0x34, mem[0x0C]=0xF2. Load a half-word from 0x0B with sext=1.
  - Response: 0xFFFFF234.
- Errors:
  - Stimulus 1: word load at 0x3E with `MEM_BYTES`=64.
  - Stimulus 2: `req_size`=11.
  - Stimulus 3: with `LSU_SPLIT_EN` undefined, a misaligned word at 0x01.
  - Response for each: `rsp_err`=1 and `rsp_rdata`=0 at T+1, with `mem_wr_en` never asserted.
- Reset mid-split:
  - Stimulus: drop `rst` during the 2nd byte of a misaligned word store.
  - Response: outputs go to reset values immediately, no `rsp_valid` is produced, and `req_ready` returns to 1 after reset is released.
